// File: rtl/icache_axi_refill.sv
// ---------------------------------------------------------------------------
// icache_axi_refill
//
// Turns an L1 instruction-cache line-fill miss into a single AXI4 read burst
// and gathers the returned beats into a complete cache line. The line is
// handed back to the cache by dropping I_wait for exactly one cycle. This
// block only reads; there is no write channel.
//
// Optional build macro: ICACHE_CRITICAL_WORD_FIRST_EN
//   undefined : INCR burst from the line base, crit_valid/crit_word tied to 0
//   defined   : WRAP burst starting at the missed word, beats rotated back
//               into address order, crit_valid/crit_word give an early copy
//               of the first (critical) word
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   I_req, I_addr     line-fill request (level) and miss address from cache
//   I_wait            stall to cache, low only in the completion cycle
//   I_line, I_err     filled line and error status of the completed fill
//   crit_valid/word   early critical-word pulse (optional feature)
//   AR*               AXI read-address channel (ARID/ARLEN/ARSIZE constant)
//   R*                AXI read-data channel
// ---------------------------------------------------------------------------
module icache_axi_refill #(
    parameter int              ADDR_W     = 32,
    parameter int              DATA_W     = 32,
    parameter int              LINE_WORDS = 4,
    parameter int              ID_W       = 4,
    parameter logic [ID_W-1:0] AXI_ID     = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         I_req,
    input  logic [ADDR_W-1:0]            I_addr,
    output logic                         I_wait,
    output logic [LINE_WORDS*DATA_W-1:0] I_line,
    output logic                         I_err,
    output logic                         crit_valid,
    output logic [DATA_W-1:0]            crit_word,
    output logic [ID_W-1:0]              ARID,
    output logic [ADDR_W-1:0]            ARADDR,
    output logic [7:0]                   ARLEN,
    output logic [2:0]                   ARSIZE,
    output logic [1:0]                   ARBURST,
    output logic                         ARVALID,
    input  logic                         ARREADY,
    input  logic [ID_W-1:0]              RID,
    input  logic [DATA_W-1:0]            RDATA,
    input  logic [1:0]                   RRESP,
    input  logic                         RLAST,
    input  logic                         RVALID,
    output logic                         RREADY
);

    localparam int BYTES = DATA_W / 8;
    localparam int WB    = $clog2(BYTES);
    localparam int IW    = $clog2(LINE_WORDS);
    // One extra bit so an over-long burst saturates at LINE_WORDS instead of
    // wrapping back onto word 0.
    localparam int CW    = IW + 1;

    localparam logic [CW-1:0]     CNT_FULL  = CW'(LINE_WORDS);
    localparam logic [CW-1:0]     CNT_LAST  = CW'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS * BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [ADDR_W-1:0]           addr_q, addr_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        err_q, err_d;
    logic [LINE_WORDS*DATA_W-1:0] line_q, line_d;

    logic                        beat;
    logic [IW-1:0]               widx;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(BYTES - 1);

    logic                        crit_valid_q, crit_valid_d;
    logic [DATA_W-1:0]           crit_word_q, crit_word_d;

    // The slave returns the missed word first, so beat k belongs at word
    // (w0 + k) mod LINE_WORDS; the IW-bit add wraps for free.
    assign widx    = cnt_q[IW-1:0] + addr_q[WB +: IW];
    assign ARADDR  = addr_q & WORD_MASK;
    assign ARBURST = 2'b10;
    assign crit_valid = crit_valid_q;
    assign crit_word  = crit_word_q;
`else
    assign widx    = cnt_q[IW-1:0];
    assign ARADDR  = addr_q & LINE_MASK;
    assign ARBURST = 2'b01;
    assign crit_valid = 1'b0;
    assign crit_word  = '0;
`endif

    assign ARID    = AXI_ID;
    assign ARLEN   = 8'(LINE_WORDS - 1);
    assign ARSIZE  = 3'(WB);
    assign ARVALID = (state_q == S_AR);
    assign RREADY  = (state_q == S_R);
    assign beat    = RVALID && (state_q == S_R);

    assign I_wait  = I_req && (state_q != S_DONE);
    assign I_line  = line_q;
    assign I_err   = err_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        line_d  = line_q;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        crit_valid_d = 1'b0;
        crit_word_d  = crit_word_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (I_req) begin
                    addr_d  = I_addr;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    // Cleared here so words missing from a short burst read 0.
                    line_d  = '0;
                    state_d = S_AR;
                end
            end
            S_AR: begin
                if (ARREADY) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (beat) begin
                    if (cnt_q < CNT_FULL) begin
                        line_d[int'(widx)*DATA_W +: DATA_W] = RDATA;
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                    if ((RRESP != 2'b00) || (RID != AXI_ID)) begin
                        err_d = 1'b1;
                    end
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
                    if (cnt_q == '0) begin
                        crit_valid_d = 1'b1;
                        crit_word_d  = RDATA;
                    end
`endif
                    if (RLAST) begin
                        // Anything but exactly LINE_WORDS beats is a bad burst.
                        if (cnt_q != CNT_LAST) begin
                            err_d = 1'b1;
                        end
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            line_q  <= line_d;
        end
    end

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crit_valid_q <= 1'b0;
            crit_word_q  <= '0;
        end else begin
            crit_valid_q <= crit_valid_d;
            crit_word_q  <= crit_word_d;
        end
    end
`endif

endmodule

// File: tb/tb_icache_axi_refill.sv
module tb_icache_axi_refill;

    localparam int LW = 4;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          I_req = 1'b0;
    logic [31:0]   I_addr = '0;
    logic          I_wait;
    logic [127:0]  I_line;
    logic          I_err;
    logic          crit_valid;
    logic [31:0]   crit_word;
    logic [3:0]    ARID;
    logic [31:0]   ARADDR;
    logic [7:0]    ARLEN;
    logic [2:0]    ARSIZE;
    logic [1:0]    ARBURST;
    logic          ARVALID;
    logic          ARREADY = 1'b0;
    logic [3:0]    RID = '0;
    logic [31:0]   RDATA = '0;
    logic [1:0]    RRESP = '0;
    logic          RLAST = 1'b0;
    logic          RVALID = 1'b0;
    logic          RREADY;

    icache_axi_refill dut (
        .clk(clk), .rst(rst),
        .I_req(I_req), .I_addr(I_addr), .I_wait(I_wait), .I_line(I_line), .I_err(I_err),
        .crit_valid(crit_valid), .crit_word(crit_word),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expectations of the current fill, filled in by the model in run_fill.
    bit            active = 1'b0;
    int            cyc = 0;
    int            exp_done;
    int            exp_crit_cyc;
    logic [127:0]  exp_line;
    logic          exp_err;
    logic [31:0]   exp_araddr;
    logic [31:0]   exp_crit;
    // Observations recorded for the hand-computed pins.
    logic [127:0]  last_line;
    logic          last_err;
    logic [31:0]   last_araddr;
    int            done_seen_cyc;
    logic          prev_arv = 1'b0;
    logic          prev_arr = 1'b0;
    logic [31:0]   prev_ara = '0;

    // Compare process: mid-cycle sampling of every meaningful output.
    always @(negedge clk) begin
        if (rst) begin
            prev_arv = 1'b0;
        end else begin
            if (ARVALID) begin
                check("araddr", ARADDR, exp_araddr);
                check("arlen", ARLEN, 8'd3);
                check("arsize", ARSIZE, 3'd2);
                check("arburst", ARBURST, WRAP ? 2'b10 : 2'b01);
                check("arid", ARID, 4'd0);
                last_araddr = ARADDR;
            end
            if (prev_arv && !prev_arr) begin
                check("ar_hold_valid", ARVALID, 1'b1);
                check("ar_hold_addr", ARADDR, prev_ara);
            end
            prev_arv = ARVALID;
            prev_arr = ARREADY;
            prev_ara = ARADDR;
            if (active) begin
                if (!I_wait && done_seen_cyc < 0) done_seen_cyc = cyc;
                check("i_wait", I_wait, (cyc != exp_done));
                check("crit_valid", crit_valid, WRAP && (cyc == exp_crit_cyc));
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
                if (cyc == exp_crit_cyc) check("crit_word", crit_word, exp_crit);
`else
                check("crit_word", crit_word, 32'd0);
`endif
                if (cyc == exp_done) begin
                    check("i_line", I_line, exp_line);
                    check("i_err", I_err, exp_err);
                    last_line = I_line;
                    last_err  = I_err;
                    active = 1'b0;
                end
            end
        end
    end

    // Runs one fill against a scripted slave. bad_resp/bad_id name the beat
    // carrying SLVERR / a foreign RID (-1 for none); rst_at names a cycle at
    // which reset is pulsed mid-transaction (-1 for none).
    task automatic run_fill(input logic [31:0] addr, input int d, input int nb,
                            input int bad_resp, input int bad_id,
                            input logic [31:0] dbase, input int rst_at);
        logic [31:0]  dat[16];
        logic [127:0] line;
        int           w0;
        int           idx;
        int           k;
        bit           was_rst;
        for (int i = 0; i < 16; i++) dat[i] = dbase * 32'(i + 1);
        w0   = int'((addr >> 2) % LW);
        line = '0;
        for (int i = 0; i < nb && i < LW; i++) begin
            idx = WRAP ? (w0 + i) % LW : i;
            line[idx*32 +: 32] = dat[i];
        end
        exp_line     = line;
        exp_err      = (nb != LW) || (bad_resp >= 0 && bad_resp < nb) || (bad_id >= 0 && bad_id < nb);
        exp_araddr   = WRAP ? (addr & ~32'h3) : (addr & ~32'hF);
        exp_done     = 2 + d + nb;
        exp_crit_cyc = 3 + d;
        exp_crit     = dat[0];
        done_seen_cyc = -1;
        was_rst = 1'b0;

        @(posedge clk); #1;
        cyc = 0;
        I_req = 1'b1;
        I_addr = addr;
        ARREADY = 1'b0;
        RVALID = 1'b0;
        active = 1'b1;
        while (active && cyc < exp_done + 20) begin
            @(posedge clk); #1;
            cyc++;
            // Address changes after capture must be ignored.
            I_addr = addr ^ 32'hFFFF_0000;
            if (cyc == rst_at) begin
                check("rready_before_rst", RREADY, 1'b1);
                active = 1'b0;
                was_rst = 1'b1;
                rst = 1'b1;
                #1;
                check("arvalid_async_rst", ARVALID, 1'b0);
                check("rready_async_rst", RREADY, 1'b0);
            end
            ARREADY = (cyc == 1 + d);
            k = cyc - 2 - d;
            if (k >= 0 && k < nb) begin
                RVALID = 1'b1;
                RDATA  = dat[k];
                RRESP  = (k == bad_resp) ? 2'b10 : 2'b00;
                RID    = (k == bad_id) ? 4'd5 : 4'd0;
                RLAST  = (k == nb - 1);
            end else begin
                RVALID = 1'b0;
                RDATA  = '0;
                RRESP  = '0;
                RID    = '0;
                RLAST  = 1'b0;
            end
        end
        if (active) begin
            checks++;
            failures++;
            $display("FAIL timeout addr=%0h actual=no_completion required=cycle_%0d", addr, exp_done);
            active = 1'b0;
        end
        I_req = 1'b0;
        ARREADY = 1'b0;
        RVALID = 1'b0;
        RLAST = 1'b0;
        if (was_rst) begin
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            check("line_after_rst", I_line, 128'd0);
            check("err_after_rst", I_err, 1'b0);
        end else begin
            repeat (2) @(posedge clk);
            #1;
            check("line_hold", I_line, exp_line);
        end
    endtask

    initial begin
        #2;
        check("rst_arvalid", ARVALID, 1'b0);
        check("rst_rready", RREADY, 1'b0);
        check("rst_line", I_line, 128'd0);
        check("rst_err", I_err, 1'b0);
        check("rst_crit_valid", crit_valid, 1'b0);
        check("rst_crit_word", crit_word, 32'd0);
        check("rst_wait", I_wait, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Ideal slave, pinned against hand-computed values.
        run_fill(32'h0000_1234, 0, 4, -1, -1, 32'h11, -1);
        check("pin_line_ideal", last_line,
              WRAP ? 128'h00000033_00000022_00000011_00000044
                   : 128'h00000044_00000033_00000022_00000011);
        check("pin_araddr_ideal", last_araddr, WRAP ? 32'h0000_1234 : 32'h0000_1230);
        check("pin_done_cycle", done_seen_cyc, 6);
        check("pin_err_ideal", last_err, 1'b0);

        // ARREADY held off for 5 cycles.
        run_fill(32'h0000_2008, 5, 4, -1, -1, 32'h1000_0001, -1);
        check("pin_done_cycle_delayed", done_seen_cyc, 11);

        // SLVERR on beat 2, then a clean fill clears the error.
        run_fill(32'h0000_300C, 0, 4, 1, -1, 32'h0A0A_0A0A, -1);
        check("pin_err_slverr", last_err, 1'b1);
        run_fill(32'h0000_3010, 0, 4, -1, -1, 32'h0505_0505, -1);
        check("pin_err_clean", last_err, 1'b0);

        // Short burst: RLAST on beat 2.
        run_fill(32'h0000_4000, 0, 2, -1, -1, 32'h0000_0101, -1);
        check("pin_short_hi_words", last_line[127:64], 64'd0);
        check("pin_short_done", done_seen_cyc, 4);

        // Long burst: six beats, extras discarded.
        run_fill(32'h0000_5000, 1, 6, -1, -1, 32'h0000_0202, -1);
        check("pin_long_done", done_seen_cyc, 9);

        // Foreign RID on the last beat.
        run_fill(32'h0000_6004, 0, 4, -1, 3, 32'h0000_0303, -1);

        // Critical-word case (plain INCR fill when the feature is off).
        run_fill(32'h0000_1238, 0, 4, -1, -1, 32'h11, -1);
        check("pin_line_crit", last_line,
              WRAP ? 128'h00000022_00000011_00000044_00000033
                   : 128'h00000044_00000033_00000022_00000011);
        check("pin_araddr_crit", last_araddr, WRAP ? 32'h0000_1238 : 32'h0000_1230);

        // Reset during R after the first beat, then a clean fill at 0x40.
        run_fill(32'h0000_7000, 0, 4, -1, -1, 32'h0000_0404, 4);
        run_fill(32'h0000_0040, 0, 4, -1, -1, 32'h0000_0606, -1);
        check("pin_line_after_rst", last_line,
              128'h00001818_00001212_00000C0C_00000606);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache_axi_refill.md
Name: icache_axi_refill

Overview:
- Downstream neighbour of the L1 instruction cache, inside the CPU wrapper.
- Converts a cache line-fill miss request into one AXI4 read burst on the instruction master port.
- Gathers the returned beats into a full cache line and hands the line back with a wait/ready handshake.
- Read-only: instruction fetch never writes memory.

Parameters:
- ADDR_W, 32, address width of I_addr and ARADDR.
- DATA_W, 32, AXI RDATA width; one word per beat.
- LINE_WORDS, 4, words per cache line; power of two, 2..16.
- ID_W, 4, AXI ID width.
- AXI_ID, 0, constant ARID driven on every request.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- I_req  in  1  line-fill request from cache; level, held until I_wait falls.
- I_addr  in  ADDR_W  miss address (any byte within the line).
- I_wait  out  1  stall to cache; low for exactly the completion cycle.
- I_line  out  LINE_WORDS*DATA_W  filled line; word k at bits [DATA_W*k+DATA_W-1 : DATA_W*k].
- I_err  out  1  error status for the completed fill; valid while I_wait=0.
- crit_valid  out  1  critical word early pulse (optional feature; 0 otherwise).
- crit_word  out  DATA_W  critical word (optional feature; 0 otherwise).
- ARID  out  ID_W;  ARADDR  out  ADDR_W;  ARLEN  out  8;  ARSIZE  out  3;  ARBURST  out  2;  ARVALID  out  1;  ARREADY  in  1.
- RID  in  ID_W;  RDATA  in  DATA_W;  RRESP  in  2;  RLAST  in  1;  RVALID  in  1;  RREADY  out  1.

Behaviour:
- Reset values: state IDLE; ARVALID=0, RREADY=0, I_line=0, I_err=0, crit_valid=0, crit_word=0, beat counter=0.
- Constant outputs: ARID=AXI_ID, ARLEN=LINE_WORDS-1, ARSIZE=log2(DATA_W/8).
- I_wait = I_req && state!=DONE (combinational).
- FSM states: IDLE, AR, R, DONE.
- IDLE:
  - If I_req=1, capture I_addr into addr_q and clear err and the counter.
  - Next state AR.
- AR:
  - ARVALID=1.
  - ARADDR=addr_q with its low log2(LINE_WORDS*DATA_W/8) bits zeroed; ARBURST=INCR (01).
  - ARADDR is held stable until ARREADY, per the AXI rule.
  - On ARVALID&&ARREADY, next state R.
- R:
  - RREADY=1.
  - Each RVALID&&RREADY handshake writes RDATA into the line buffer at word index cnt, then increments cnt.
  - RRESP!=00 on any beat sets err (sticky for this fill).
  - RID!=AXI_ID sets err; the beat is still counted.
  - On RLAST, next state DONE.
- DONE:
  - I_wait=0, I_line=buffer, I_err=err for one cycle.
  - Next state IDLE.
- Minimum latency, with ARREADY and RVALID always high:
  - req seen in cycle 0; AR handshake in cycle 1; beats in cycles 2..1+LINE_WORDS.
  - DONE in cycle 2+LINE_WORDS, i.e. 6 cycles for LINE_WORDS=4.
- I_line holds its value from DONE until the next IDLE capture.
- I_addr changes after capture are ignored.
- Short burst (RLAST before LINE_WORDS beats): unfilled words keep the value 0 cleared at capture; err=1.
- Long burst (cnt reaches LINE_WORDS without RLAST): extra beats are accepted and discarded; err=1; DONE only after RLAST.
- Counter width is log2(LINE_WORDS)+1, so cnt does not wrap during overflow detection.
- If I_req is still high in the cycle after DONE, a new fill starts; the cache must drop I_req on seeing I_wait=0.
- I_req deasserted while in AR or R: the transaction still completes, since AXI cannot be aborted. DONE is reached normally and I_wait stays 0.
- rst asserted mid-transaction: immediate return to IDLE, ARVALID/RREADY drop asynchronously. The AXI interconnect shares the same reset.

Optional Feature:
- Macro: ICACHE_CRITICAL_WORD_FIRST_EN.
- Defined:
  - ARBURST=WRAP (10); ARADDR=addr_q word-aligned.
  - Beat k is stored at word index (w0+k) mod LINE_WORDS, where w0 is the requested word index.
  - On the first beat, crit_valid pulses 1 for one cycle and crit_word=RDATA.
  - The DONE timing is unchanged.
- Not defined:
  - INCR burst from the line base; crit_valid and crit_word are tied to 0.

Test Plan:
- Ideal slave (ARREADY=1, RVALID=1, RDATA=0x11,0x22,0x33,0x44, RLAST on beat 4), I_addr=0x0000_1234 -> ARADDR=0x0000_1230, ARLEN=3. Single I_wait=0 cycle in cycle 6, I_line=0x00000044_00000033_00000022_00000011, I_err=0.
- ARREADY delayed 5 cycles -> ARADDR/ARVALID stable throughout; completion delayed by exactly 5 cycles.
- RRESP=SLVERR (10) on beat 2 -> all 4 beats accepted, I_err=1 in DONE; next clean fill gives I_err=0.
- RLAST on beat 2 -> DONE after beat 2, words 2-3 = 0, I_err=1.
- rst pulsed during R after beat 1 -> ARVALID=RREADY=0 immediately. A subsequent request with I_addr=0x40 fills correctly.
- With ICACHE_CRITICAL_WORD_FIRST_EN, I_addr=0x0000_1238 -> ARADDR=0x0000_1238, ARBURST=10. crit_valid pulses with the first RDATA, which is stored as word 2, and the line is reassembled in address order.
